// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module   : clock_divider_prog
// Brief    : Multi-channel programmable clock divider with glitch-free,
//            boundary-aligned divisor and enable changes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_prog #(
  parameter int NUM_CH      = 2,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int CH_W        = 1
) (
  input  logic                 clockIn,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    enIn,
  input  logic [DIV_WIDTH-1:0] divIn,
  input  logic [CH_W-1:0]      chSel,
  input  logic                 divLoad,
  output logic [NUM_CH-1:0]    clockOut,
  output logic [NUM_CH-1:0]    tickOut,
  output logic [NUM_CH-1:0]    pendingOut,
  output logic [NUM_CH-1:0]    runningOut
);

  localparam logic [DIV_WIDTH-1:0] c_DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] c_ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] c_TWO     = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH:0]   c_ONE_X   = (DIV_WIDTH+1)'(1);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t               r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
    logic [DIV_WIDTH-1:0] r_pdiv, w_pdiv_nxt;
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_pend, w_pend_nxt;
    logic                 r_clk, w_clk_nxt;
    logic                 r_tick, w_tick_nxt;
    logic                 w_load;
    logic                 w_apply;
    logic                 w_boundary;
    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [DIV_WIDTH:0]   w_half;
    logic [DIV_WIDTH:0]   w_cnt_inc;

    assign w_load     = divLoad && (int'(chSel) == i);
    // The divisor that will govern the next period once any pending value lands.
    assign w_div_eff  = r_pend ? r_pdiv : r_div;
    assign w_half     = ({1'b0, r_div} + c_ONE_X) >> 1;
    assign w_cnt_inc  = {1'b0, r_cnt} + c_ONE_X;
    assign w_boundary = (r_cnt == (r_div - c_ONE));

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clk_nxt   = r_clk;
      w_tick_nxt  = 1'b0;
      w_apply     = 1'b0;
      case (r_state)
        ST_STOPPED: begin
          w_apply   = r_pend;
          w_cnt_nxt = '0;
          if (enIn[i] && (w_div_eff >= c_TWO)) begin
            w_state_nxt = ST_RUNNING;
            w_clk_nxt   = 1'b1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_clk_nxt   = 1'b0;
          end
        end
        ST_RUNNING: begin
          if (w_boundary) begin
            w_apply   = r_pend;
            w_cnt_nxt = '0;
            if (!enIn[i] || (w_div_eff < c_TWO)) begin
              w_state_nxt = ST_STOPPED;
              w_clk_nxt   = 1'b0;
            end else begin
              w_clk_nxt   = 1'b1;
              w_tick_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc[DIV_WIDTH-1:0];
            w_clk_nxt = (w_cnt_inc < w_half);
          end
        end
        default: begin
          w_state_nxt = ST_STOPPED;
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
        end
      endcase
    end

    // A load landing on a boundary keeps pending set: the boundary consumed the older value.
    always_comb begin
      w_div_nxt  = w_apply ? r_pdiv : r_div;
      w_pdiv_nxt = w_load ? divIn : r_pdiv;
      w_pend_nxt = w_load ? 1'b1 : (w_apply ? 1'b0 : r_pend);
    end

    always_ff @(posedge clockIn or negedge reset) begin
      if (!reset) begin
        r_state <= ST_STOPPED;
        r_div   <= c_DIV_RST;
        r_pdiv  <= '0;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_clk   <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_div   <= w_div_nxt;
        r_pdiv  <= w_pdiv_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pend  <= w_pend_nxt;
        r_clk   <= w_clk_nxt;
        r_tick  <= w_tick_nxt;
      end
    end

    assign clockOut[i]   = r_clk;
    assign tickOut[i]    = r_tick;
    assign pendingOut[i] = r_pend;
    assign runningOut[i] = (r_state == ST_RUNNING);
  end : g_ch

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// ============================================================================
// Module   : tb_clock_divider_prog
// Brief    : Directed scoreboard bench for clock_divider_prog (2 channels).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_prog;

  logic        clockIn;
  logic        reset;
  logic [1:0]  enIn;
  logic [15:0] divIn;
  logic [1:0]  chSel;
  logic        divLoad;
  logic [1:0]  clockOut, tickOut, pendingOut, runningOut;

  clock_divider_prog #(
    .NUM_CH(2), .DIV_WIDTH(16), .DEFAULT_DIV(4), .CH_W(2)
  ) dut (
    .clockIn(clockIn), .reset(reset), .enIn(enIn), .divIn(divIn),
    .chSel(chSel), .divLoad(divLoad), .clockOut(clockOut),
    .tickOut(tickOut), .pendingOut(pendingOut), .runningOut(runningOut)
  );

  typedef struct {
    int         tag;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  always @(posedge clockIn) cyc = cyc + 1;

  // Expected vectors are tagged with the rising edge after which they must hold.
  always @(negedge clockIn) begin : monitor
    exp_t       e;
    logic [7:0] act;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      e   = q.pop_front();
      act = {clockOut, tickOut, pendingOut, runningOut};
      vectors = vectors + 1;
      if (e.tag != cyc || act !== e.v) begin
        miscompares = miscompares + 1;
        $display("FAIL vec@edge%0d clk/tick/pend/run got %b_%b_%b_%b want %b_%b_%b_%b (edge %0d)",
                 e.tag, act[7:6], act[5:4], act[3:2], act[1:0],
                 e.v[7:6], e.v[5:4], e.v[3:2], e.v[1:0], cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [1:0] c, input logic [1:0] t,
                      input logic [1:0] p, input logic [1:0] r);
    exp_t e;
    e.tag = cyc + 1;
    e.v   = {c, t, p, r};
    q.push_back(e);
    @(negedge clockIn);
    divLoad = 1'b0;
  endtask

  // Channel 1 idle: only channel 0 bits given.
  task automatic s0(input logic c, input logic t, input logic p, input logic r);
    step({1'b0, c}, {1'b0, t}, {1'b0, p}, {1'b0, r});
  endtask

  task automatic load(input logic [1:0] sel, input logic [15:0] d);
    divLoad = 1'b1;
    chSel   = sel;
    divIn   = d;
  endtask

  task automatic chk_zero(input string name);
    logic [7:0] act;
    act = {clockOut, tickOut, pendingOut, runningOut};
    vectors = vectors + 1;
    if (act !== 8'h00) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got %h want 00", name, act);
    end
  endtask

  initial begin
    reset = 1'b0; enIn = 2'b00; divLoad = 1'b0; chSel = 2'd0; divIn = 16'd0;
    repeat (2) @(negedge clockIn);
    chk_zero("reset_state");
    reset = 1'b1;
    enIn  = 2'b01;

    // Default divide-by-4 on ch0
    s0(1,1,0,1); s0(1,0,0,1); s0(0,0,0,1); s0(0,0,0,1);
    s0(1,1,0,1); s0(1,0,0,1); s0(0,0,0,1); s0(0,0,0,1);
    s0(1,1,0,1); s0(1,0,0,1);
    // Load 5 mid-period: current period finishes at D=4
    load(2'd0, 16'd5);
    s0(0,0,1,1); s0(0,0,1,1);
    s0(1,1,0,1); s0(1,0,0,1); s0(1,0,0,1); s0(0,0,0,1); s0(0,0,0,1);
    s0(1,1,0,1); s0(1,0,0,1); s0(1,0,0,1); s0(0,0,0,1); s0(0,0,0,1);
    s0(1,1,0,1);
    // Switch to D=6
    load(2'd0, 16'd6);
    s0(1,0,1,1); s0(1,0,1,1); s0(0,0,1,1); s0(0,0,1,1);
    s0(1,1,0,1);
    // Drop enable right after the boundary: period completes then stops
    enIn = 2'b00;
    s0(1,0,0,1); s0(1,0,0,1); s0(0,0,0,1); s0(0,0,0,1); s0(0,0,0,1);
    s0(0,0,0,0); s0(0,0,0,0);
    enIn = 2'b01;
    s0(1,1,0,1);
    enIn = 2'b00;
    s0(1,0,0,1);
    enIn = 2'b01;
    s0(1,0,0,1); s0(0,0,0,1); s0(0,0,0,1); s0(0,0,0,1);
    s0(1,1,0,1);

    // ch1 joins (D=4); ch0 keeps D=6
    enIn = 2'b11;
    step(2'b11, 2'b10, 2'b00, 2'b11);
    load(2'd1, 16'd1);
    step(2'b11, 2'b00, 2'b10, 2'b11);
    step(2'b00, 2'b00, 2'b10, 2'b11);
    step(2'b00, 2'b00, 2'b10, 2'b11);
    step(2'b00, 2'b00, 2'b00, 2'b01);
    step(2'b01, 2'b01, 2'b00, 2'b01);
    load(2'd1, 16'd3);
    step(2'b01, 2'b00, 2'b10, 2'b01);
    step(2'b11, 2'b10, 2'b00, 2'b11);
    step(2'b10, 2'b00, 2'b00, 2'b11);
    step(2'b00, 2'b00, 2'b00, 2'b11);
    step(2'b10, 2'b10, 2'b00, 2'b11);
    // Load coincident with ch0 boundary: old D=6 repeats once
    load(2'd0, 16'd8);
    step(2'b11, 2'b01, 2'b01, 2'b11);
    step(2'b01, 2'b00, 2'b01, 2'b11);
    step(2'b11, 2'b10, 2'b01, 2'b11);
    step(2'b10, 2'b00, 2'b01, 2'b11);
    step(2'b00, 2'b00, 2'b01, 2'b11);
    step(2'b10, 2'b10, 2'b01, 2'b11);
    step(2'b11, 2'b01, 2'b00, 2'b11);
    step(2'b01, 2'b00, 2'b00, 2'b11);
    // Out-of-range channel select must be ignored
    load(2'd3, 16'd2);
    step(2'b11, 2'b10, 2'b00, 2'b11);
    step(2'b11, 2'b00, 2'b00, 2'b11);
    step(2'b00, 2'b00, 2'b00, 2'b11);
    step(2'b10, 2'b10, 2'b00, 2'b11);
    step(2'b10, 2'b00, 2'b00, 2'b11);
    step(2'b00, 2'b00, 2'b00, 2'b11);
    // Simultaneous boundaries on both channels
    step(2'b11, 2'b11, 2'b00, 2'b11);
    load(2'd1, 16'd5);
    step(2'b11, 2'b00, 2'b10, 2'b11);

    // Asynchronous reset mid-high-phase, between clock edges
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clockIn);
    reset = 1'b1;
    enIn  = 2'b11;
    step(2'b11, 2'b11, 2'b00, 2'b11);
    step(2'b11, 2'b00, 2'b00, 2'b11);
    step(2'b00, 2'b00, 2'b00, 2'b11);
    step(2'b00, 2'b00, 2'b00, 2'b11);
    step(2'b11, 2'b11, 2'b00, 2'b11);

    @(negedge clockIn);
    if (q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain got %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Multi-channel programmable clock divider; next generation of the fixed divide-by-4 divider.
- Each channel derives a divided clock-enable waveform plus a one-cycle period tick from a single fast clock.
- Per-channel runtime divisor and enable.
- Divisor and enable changes take effect only at period boundaries, so outputs never glitch or produce runt phases.
- Sits between the board clock and the slow-clocked logic (SPI bit timing, router pacing).

Parameters:
- NUM_CH, 2, number of independent divider channels (1..16).
- DIV_WIDTH, 16, divisor width in bits; maximum divisor 2^DIV_WIDTH-1.
- DEFAULT_DIV, 4, divisor loaded into every channel at reset.
- CH_W, 1, width of channel select; must be at least ceil(log2(NUM_CH)), minimum 1.

Ports:
- clockIn  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enIn  input  NUM_CH  per-channel run request, level sensitive.
- divIn  input  DIV_WIDTH  new divisor value.
- chSel  input  CH_W  channel addressed by divLoad.
- divLoad  input  1  one-cycle write strobe for divIn into channel chSel.
- clockOut  output  NUM_CH  registered divided waveform per channel.
- tickOut  output  NUM_CH  registered one-cycle pulse, high on the first cycle of each period.
- pendingOut  output  NUM_CH  high while a loaded divisor awaits its boundary.
- runningOut  output  NUM_CH  high while the channel is counting.

Behaviour:
- Per-channel state:
  - active divisor D, reset DEFAULT_DIV
  - pending divisor P and pending flag
  - counter cnt (DIV_WIDTH bits), reset 0
  - running flag, reset 0
- Reset (reset=0, asynchronous): all outputs 0, cnt=0, running=0, pending=0, D=DEFAULT_DIV.
- Load:
  - On divLoad=1 with chSel<NUM_CH: P[chSel]<=divIn and pending[chSel]<=1.
  - A second load before the boundary overwrites P.
  - chSel>=NUM_CH: load ignored, no state change.
- H = ceil(D/2) = (D+1)>>1. High phase is H cycles, low phase is D-H cycles. Odd D gives the extra cycle to the high phase.
- States per channel: STOPPED, RUNNING.
- STOPPED, each edge:
  - If pending: D<=P, pending<=0 (applied immediately).
  - If enIn=1 and the effective D>=2: go to RUNNING with cnt=0, clockOut<=1, tickOut<=1.
  - Otherwise remain STOPPED with clockOut=0 and tickOut=0.
- RUNNING, cnt<D-1: cnt<=cnt+1, clockOut<=(cnt+1<H), tickOut<=0.
- RUNNING, cnt==D-1 (boundary):
  - If pending: D<=P, pending<=0.
  - If enIn=0 or the effective D<2: go to STOPPED, cnt<=0, clockOut<=0, tickOut<=0.
  - Otherwise cnt<=0, clockOut<=1, tickOut<=1, using the new D for H.
- Latency: first tick on the first edge after enIn rises in STOPPED. Output is visible 1 clockIn cycle after that edge samples enIn.
- enIn deasserted mid-period: the current period completes in full, then the channel stops. enIn reasserted before the boundary: no interruption.
- divLoad to channel c in the same cycle as its boundary: the boundary uses the old P state. The new value stays pending until the next boundary.
- Divisor 0 or 1 is legal to load. It stops the channel at the next boundary and keeps it STOPPED while that value is active.
- Counter never exceeds D-1. No wrap beyond 2^DIV_WIDTH-1 is possible.
- Channels are fully independent. Simultaneous boundaries on several channels are all honoured in the same cycle.
- Reset mid-period: all outputs drop immediately (asynchronous). Pending loads are lost.
- runningOut = running flag; pendingOut = pending flag; both registered.

Test Plan:
- Reset release, enIn=2'b01, DEFAULT_DIV=4 -> ch0 clockOut pattern 1,1,0,0 repeating, tickOut every 4th cycle coincident with the rise; ch1 stays 0, runningOut=2'b01.
- Load divIn=5 to ch0 mid-period at cnt=1 -> pendingOut[0]=1; current period finishes with D=4; then pattern 1,1,1,0,0 (H=3), pendingOut clears at the boundary.
- Drop enIn[0] at cnt=0 with D=6 -> 6 more cycles, 3 high then 3 low, then clockOut=0 and runningOut[0]=0; re-raise enIn -> tick on the next edge.
- Load divIn=1 to a running ch1 -> ch1 stops at its boundary; load 3 -> restarts immediately with 1,1,0 and pendingOut clears same cycle.
- divLoad coincident with ch0 boundary, chSel=0, divIn=8 -> old D period repeats once; D=8 applies at the following boundary; chSel=3 with NUM_CH=2 -> no effect.
- Assert reset low mid-high-phase -> clockOut, tickOut, runningOut, pendingOut go 0 without waiting for a clockIn edge; after release, D=DEFAULT_DIV.
